clk_burst_gate: RTL and testbench
=================================

// Module: clk_burst_gate
// PURPOSE
//  Downstream consumer of the divided clock (div-by-20 of clk_in). Samples the divided clock in
//  the clk_in domain, detects its rising edges and, on command, passes exactly burst_len full
//  periods of it to clk_gated (NMR excitation/acquisition burst), then reports done.
//  Single clock domain: clk_in. Asynchronous active-low reset rst_n.
// PARAMETERS
//  CNT_W        16  width of burst_len and edge_cnt
//  SYNC_STAGES   2  synchroniser flops on div_clk_in (>=2)
// PORTS
//  clk_in      in   1      system clock, all logic on posedge
//  rst_n       in   1      async active-low reset
//  div_clk_in  in   1      divided clock from the upstream divider (treated as data)
//  start       in   1      1-cycle request to begin a burst
//  abort       in   1      1-cycle request to cancel a burst
//  burst_len   in   CNT_W  number of divided-clock periods to pass; sampled on accepted start
//  gate_out    out  1      high while burst window is open
//  clk_gated   out  1      registered div clock, forced low outside the window
//  edge_cnt    out  CNT_W  periods passed in current/last burst
//  busy        out  1      high in ARM and BURST
//  done        out  1      1-cycle pulse when burst completes normally
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, sync/edge flops 0, state IDLE, len latch 0.
//  - Sync chain: s_sync = last of SYNC_STAGES flops; s_prev = s_sync delayed 1 cycle;
//    rise = s_sync & ~s_prev (combinational from registers).
//  - All outputs registered. clk_gated <= gate_next & s_sync every cycle (phase-aligned to gate_out).
//  - States: IDLE, ARM, BURST, DONE.
//   IDLE : start & burst_len!=0 -> len_q<=burst_len, edge_cnt<=0, ARM.
//          start & burst_len==0 -> edge_cnt<=0, done=1 next cycle, stay IDLE.
//   ARM  : wait for rise; on rise -> gate_out<=1, edge_cnt<=1, BURST. Mid-high div clock at
//          start is not counted; window opens only on a clean rising edge.
//   BURST: on rise: if edge_cnt==len_q -> gate_out<=0, DONE; else edge_cnt<=edge_cnt+1.
//          Result: exactly len_q high phases on clk_gated, each full-length.
//   DONE : done<=1 for one cycle, -> IDLE.
//  - Latency: start -> ARM 1 cycle; div_clk_in rising edge -> gate_out/clk_gated high
//    SYNC_STAGES+1 clk_in cycles; closing edge -> gate_out low same latency.
//  - start while busy (ARM/BURST/DONE) ignored; burst_len changes after acceptance ignored.
//  - abort in any state: next cycle state IDLE, gate_out=0, clk_gated=0, busy=0, no done;
//    edge_cnt holds its value. abort and start in same cycle: abort wins, start dropped.
//  - edge_cnt never wraps: max value len_q <= 2^CNT_W-1.
//  - Reset mid-burst: outputs drop immediately; after release stay IDLE until new start.
// TESTING  (div_clk_in period 20 clk_in cycles, 10 high/10 low, SYNC_STAGES=2)
//  1. start, burst_len=3 -> gate_out high 60 cycles; 3 clk_gated pulses of 10 cycles each;
//     done 1 cycle after gate falls; edge_cnt=3; busy low with done.
//  2. start, burst_len=0 -> done high the next cycle only; gate_out/clk_gated stay 0; busy 0.
//  3. burst_len=5, abort after 2nd clk_gated pulse -> gate_out 0 next cycle, no done,
//     edge_cnt=2, busy 0; following start len=1 gives one 10-cycle pulse.
//  4. start while div_clk_in high -> first pulse waits for next rising edge, still full 10 cycles;
//     second start and burst_len change mid-burst ignored (count stays at original len).
//  5. rst_n low during BURST -> all outputs 0 asynchronously; after release no gate until start.
//  6. abort+start same cycle in IDLE -> nothing starts; busy stays 0.

Source files
------------

// File: rtl/clk_burst_gate.sv
// clk_burst_gate: passes exactly burst_len full periods of a synchronised divided clock
// to clk_gated on command, then pulses done.
module clk_burst_gate #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             div_clk_in,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] burst_len,
    output logic             gate_out,
    output logic             clk_gated,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, ARM, BURST, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync, s_prev_q, rise;
    logic [CNT_W-1:0]       len_q, len_d, cnt_q, cnt_d;
    logic                   gate_q, gate_d, clk_gated_q, busy_q, done_q, done_d;

    assign s_sync    = sync_q[SYNC_STAGES-1];
    assign rise      = s_sync & ~s_prev_q;
    assign gate_out  = gate_q;
    assign clk_gated = clk_gated_q;
    assign edge_cnt  = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        gate_d  = gate_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            gate_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    cnt_d = '0;
                    if (burst_len != '0) begin
                        len_d   = burst_len;
                        state_d = ARM;
                    end else begin
                        done_d = 1'b1;
                    end
                end
                // only a clean rising edge opens the window, so every pulse is full-length
                ARM: if (rise) begin
                    gate_d  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = BURST;
                end
                BURST: if (rise) begin
                    if (cnt_q == len_q) begin
                        gate_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync_q      <= '0;
            s_prev_q    <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            gate_q      <= 1'b0;
            clk_gated_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], div_clk_in};
            s_prev_q    <= s_sync;
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            gate_q      <= gate_d;
            clk_gated_q <= gate_d & s_sync;
            busy_q      <= (state_d == ARM) || (state_d == BURST);
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_clk_burst_gate.sv
// tb_clk_burst_gate: directed bursts with a scoreboard of expected pulse/gate/done events.
module tb_clk_burst_gate;
    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_clk_in = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] burst_len = '0;
    logic        gate_out, clk_gated, busy, done;
    logic [15:0] edge_cnt;

    typedef struct packed {int k; int v;} ev_t;
    ev_t q[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  dph = 0;

    clk_burst_gate dut (
        .clk_in(clk_in), .rst_n(rst_n), .div_clk_in(div_clk_in), .start(start),
        .abort(abort), .burst_len(burst_len), .gate_out(gate_out), .clk_gated(clk_gated),
        .edge_cnt(edge_cnt), .busy(busy), .done(done)
    );

    always #5 clk_in = ~clk_in;

    // divided clock: 20 clk_in periods, 10 high / 10 low, changing on the falling edge
    initial forever begin
        @(negedge clk_in);
        dph = (dph + 1) % 20;
        div_clk_in = dph < 10;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic expect_ev(input int k, input int v);
        q.push_back('{k: k, v: v});
    endtask

    task automatic observe(input int k, input int v);
        ev_t e;
        string nm;
        if (q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got kind %0d value %0d expected none", k, v);
        end else begin
            e = q.pop_front();
            nm = e.k == 0 ? "pulse_width" : e.k == 1 ? "gate_width" : "done_busy_gate_cnt";
            chk(nm, k * 1000000 + v, e.k * 1000000 + e.v);
        end
    endtask

    // monitor: turns clk_gated/gate_out falls and done cycles into events
    initial begin
        logic gp, cp;
        int   gw, cw;
        gp = 0; cp = 0; gw = 0; cw = 0;
        forever begin
            @(negedge clk_in);
            if (!rst_n) begin
                gp = 0; cp = 0; gw = 0; cw = 0;
            end else begin
                if (clk_gated) cw++;
                else if (cp) begin observe(0, cw); cw = 0; end
                if (gate_out) gw++;
                else if (gp) begin observe(1, gw); gw = 0; end
                if (done) observe(2, int'({busy, gate_out, edge_cnt}));
                cp = clk_gated;
                gp = gate_out;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk_in); #1;
        start = 1'b1;
        burst_len = 16'(len);
        @(posedge clk_in); #1;
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while (q.size() != 0 && t < 400) begin @(negedge clk_in); t++; end
        repeat (30) @(negedge clk_in);
        chk(nm, q.size(), 0);
    endtask

    task automatic wait_cg_falls(input int n);
        int   seen = 0;
        int   t = 0;
        logic p;
        p = clk_gated;
        while (seen < n && t < 400) begin
            @(negedge clk_in);
            t++;
            if (p && !clk_gated) seen++;
            p = clk_gated;
        end
        chk("wait_clk_gated_falls", seen, n);
    endtask

    initial begin
        int t, hi;
        cycles(3);
        chk("reset_outputs", int'({gate_out, clk_gated, busy, done, edge_cnt}), 0);
        rst_n = 1'b1;
        cycles(25);

        // 1: three full periods
        expect_ev(0, 10); expect_ev(0, 10); expect_ev(0, 10); expect_ev(1, 60); expect_ev(2, 3);
        pulse_start(3);
        @(negedge clk_in);
        chk("t1_busy_after_start", int'(busy), 1);
        drain("t1_drain");

        // 2: zero length completes immediately
        expect_ev(2, 0);
        pulse_start(0);
        @(negedge clk_in);
        chk("t2_done_next_cycle", int'({done, busy, gate_out, clk_gated}), 8);
        @(negedge clk_in);
        chk("t2_done_one_cycle", int'(done), 0);
        drain("t2_drain");

        // 3: abort after the second pulse, then a single-period burst
        expect_ev(0, 10); expect_ev(0, 10); expect_ev(1, 32);
        pulse_start(5);
        wait_cg_falls(2);
        @(posedge clk_in); #1;
        abort = 1'b1;
        @(posedge clk_in); #1;
        abort = 1'b0;
        @(negedge clk_in);
        chk("t3_abort_state", int'({gate_out, clk_gated, busy, done}), 0);
        chk("t3_abort_cnt", int'(edge_cnt), 2);
        drain("t3_no_done");
        expect_ev(0, 10); expect_ev(1, 20); expect_ev(2, 1);
        pulse_start(1);
        drain("t3_len1_drain");

        // 4: start mid-high; re-start and length change during the burst are ignored
        t = 0;
        while (dph != 4 && t < 40) begin @(posedge clk_in); t++; end
        #1;
        chk("t4_div_high_at_start", int'(div_clk_in), 1);
        expect_ev(0, 10); expect_ev(0, 10); expect_ev(1, 40); expect_ev(2, 2);
        start = 1'b1;
        burst_len = 16'd2;
        @(posedge clk_in); #1;
        start = 1'b0;
        wait_cg_falls(1);
        pulse_start(7);
        drain("t4_drain");

        // 5: asynchronous reset during a burst
        pulse_start(4);
        t = 0;
        while (!gate_out && t < 60) begin @(negedge clk_in); t++; end
        repeat (2) @(negedge clk_in);
        #2;
        chk("t5_gate_open_before_reset", int'(gate_out), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_reset_outputs", int'({gate_out, clk_gated, busy, done, edge_cnt}), 0);
        cycles(3);
        rst_n = 1'b1;
        hi = 0;
        repeat (60) begin @(negedge clk_in); if (gate_out || busy || clk_gated) hi++; end
        chk("t5_idle_after_reset", hi, 0);
        drain("t5_drain");

        // 6: abort wins over a simultaneous start
        @(posedge clk_in); #1;
        start = 1'b1;
        abort = 1'b1;
        burst_len = 16'd2;
        @(posedge clk_in); #1;
        start = 1'b0;
        abort = 1'b0;
        hi = 0;
        repeat (50) begin @(negedge clk_in); if (gate_out || busy || clk_gated) hi++; end
        chk("t6_abort_start_idle", hi, 0);
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
